// File: rtl/count_seq_monitor.sv
// ============================================================================
// Module   : count_seq_monitor
// Brief    : Watches the output of a 2-bit up-counter. It locks after
//            LOCK_CNT consecutive good steps, flags sequence errors while
//            locked, and counts 3->0 wraps while locked (saturating).
//            Optional build macro: STALL_OK_EN makes a hold (c_in == prev)
//            a neutral sample rather than a bad step.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module count_seq_monitor #(
  parameter int WRAP_W   = 8,
  parameter int LOCK_CNT = 2   // legal range 1..7
) (
  input  logic              clk,
  input  logic              reset,      // synchronous, active-low
  input  logic              en,
  input  logic [1:0]        c_in,
  input  logic              clr,
  output logic              locked,
  output logic              err,
  output logic              err_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACQ    = 2'd1,
    S_LOCKED = 2'd2,
    S_ERROR  = 2'd3
  } state_t;

  localparam logic [2:0]        C_LOCK_CNT = 3'(LOCK_CNT);
  localparam logic [WRAP_W-1:0] C_WRAP_MAX = {WRAP_W{1'b1}};

`ifdef STALL_OK_EN
  localparam logic C_STALL_OK = 1'b1;
`else
  localparam logic C_STALL_OK = 1'b0;
`endif

  state_t            r_state;
  logic [1:0]        r_prev;
  logic [2:0]        r_lock_cnt;
  logic              r_locked;
  logic              r_err;
  logic              r_err_pulse;
  logic [WRAP_W-1:0] r_wrap_cnt;

  state_t            w_state_n;
  logic [1:0]        w_prev_n;
  logic [2:0]        w_lock_cnt_n;
  logic              w_err_n;
  logic              w_err_pulse_n;
  logic [WRAP_W-1:0] w_wrap_cnt_n;

  logic              w_good;
  logic              w_hold;
  logic              w_neutral;
  logic [2:0]        w_lock_inc;

  // 3->0 is a good step because the increment wraps in 2 bits
  assign w_good     = (c_in == (r_prev + 2'd1));
  assign w_hold     = (c_in == r_prev);
  assign w_neutral  = w_hold && C_STALL_OK;
  assign w_lock_inc = r_lock_cnt + 3'd1;

  // Next-state and next-output decode; clr wins over en and discards the sample
  always_comb begin
    w_state_n     = r_state;
    w_prev_n      = r_prev;
    w_lock_cnt_n  = r_lock_cnt;
    w_err_n       = r_err;
    w_err_pulse_n = 1'b0;
    w_wrap_cnt_n  = r_wrap_cnt;

    if (clr) begin
      w_state_n    = S_IDLE;
      w_lock_cnt_n = 3'd0;
      w_err_n      = 1'b0;
      w_wrap_cnt_n = '0;
    end else if (en) begin
      case (r_state)
        S_IDLE: begin
          // First sample only seeds prev; nothing to compare against yet
          w_prev_n     = c_in;
          w_lock_cnt_n = 3'd0;
          w_state_n    = S_ACQ;
        end
        S_ACQ: begin
          w_prev_n = c_in;
          if (w_good) begin
            w_lock_cnt_n = w_lock_inc;
            if (w_lock_inc >= C_LOCK_CNT) begin
              w_state_n = S_LOCKED;
            end
          end else if (!w_neutral) begin
            w_lock_cnt_n = 3'd0;
          end
        end
        S_LOCKED: begin
          w_prev_n = c_in;
          if (w_good) begin
            if ((r_prev == 2'd3) && (r_wrap_cnt != C_WRAP_MAX)) begin
              w_wrap_cnt_n = r_wrap_cnt + 1'b1;
            end
          end else if (!w_neutral) begin
            w_state_n     = S_ERROR;
            w_err_n       = 1'b1;
            w_err_pulse_n = 1'b1;
          end
        end
        default: begin
          // ERROR is terminal until clr or reset; prev stays frozen
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_prev      <= 2'd0;
      r_lock_cnt  <= 3'd0;
      r_locked    <= 1'b0;
      r_err       <= 1'b0;
      r_err_pulse <= 1'b0;
      r_wrap_cnt  <= '0;
    end else begin
      r_state     <= w_state_n;
      r_prev      <= w_prev_n;
      r_lock_cnt  <= w_lock_cnt_n;
      r_locked    <= (w_state_n == S_LOCKED);
      r_err       <= w_err_n;
      r_err_pulse <= w_err_pulse_n;
      r_wrap_cnt  <= w_wrap_cnt_n;
    end
  end

  assign state     = r_state;
  assign locked    = r_locked;
  assign err       = r_err;
  assign err_pulse = r_err_pulse;
  assign wrap_cnt  = r_wrap_cnt;

endmodule

`default_nettype wire

// File: tb/tb_count_seq_monitor.sv
// ============================================================================
// Module   : tb_count_seq_monitor
// Brief    : Self-checking bench for count_seq_monitor (default WRAP_W and a
//            WRAP_W=2 instance driven by the same stimulus). Honours the
//            STALL_OK_EN build macro.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_count_seq_monitor;

  localparam int C_LOCK_CNT = 2;

`ifdef STALL_OK_EN
  localparam bit C_STALL_OK = 1'b1;
`else
  localparam bit C_STALL_OK = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       en;
  logic [1:0] c_in;
  logic       clr;

  logic       locked_a, err_a, pulse_a;
  logic [7:0] wrap_a;
  logic [1:0] state_a;
  logic       locked_b, err_b, pulse_b;
  logic [1:0] wrap_b;
  logic [1:0] state_b;

  int n_vec = 0;
  int n_err = 0;

  count_seq_monitor #(.WRAP_W(8), .LOCK_CNT(C_LOCK_CNT)) u_dut (
    .clk(clk), .reset(reset), .en(en), .c_in(c_in), .clr(clr),
    .locked(locked_a), .err(err_a), .err_pulse(pulse_a),
    .wrap_cnt(wrap_a), .state(state_a)
  );

  count_seq_monitor #(.WRAP_W(2), .LOCK_CNT(C_LOCK_CNT)) u_dut_w2 (
    .clk(clk), .reset(reset), .en(en), .c_in(c_in), .clr(clr),
    .locked(locked_b), .err(err_b), .err_pulse(pulse_b),
    .wrap_cnt(wrap_b), .state(state_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: mode 0..3 = idle/acquiring/locked/error
  int m_mode, m_prev, m_run, m_wraps;
  bit m_err, m_pulse;

  task automatic model_step(input bit r, input bit e, input bit cl, input int c);
    bit good, neutral;
    m_pulse = 1'b0;
    if (!r) begin
      m_mode = 0; m_prev = 0; m_run = 0; m_wraps = 0; m_err = 1'b0;
    end else if (cl) begin
      m_mode = 0; m_run = 0; m_wraps = 0; m_err = 1'b0;
    end else if (e && m_mode != 3) begin
      good    = (c == (m_prev + 1) % 4);
      neutral = (c == m_prev) && C_STALL_OK;
      if (m_mode == 0) begin
        m_mode = 1; m_run = 0;
      end else if (m_mode == 1) begin
        if (good) begin
          m_run++;
          if (m_run >= C_LOCK_CNT) m_mode = 2;
        end else if (!neutral) m_run = 0;
      end else begin
        if (good) begin
          if (m_prev == 3) m_wraps++;
        end else if (!neutral) begin
          m_mode = 3; m_err = 1'b1; m_pulse = 1'b1;
        end
      end
      m_prev = c;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int w8, w2;
    w8 = (m_wraps > 255) ? 255 : m_wraps;
    w2 = (m_wraps > 3) ? 3 : m_wraps;
    check("model.state",    int'(state_a),  m_mode);
    check("model.locked",   int'(locked_a), int'(m_mode == 2));
    check("model.err",      int'(err_a),    int'(m_err));
    check("model.pulse",    int'(pulse_a),  int'(m_pulse));
    check("model.wrap8",    int'(wrap_a),   w8);
    check("model.w2.state", int'(state_b),  m_mode);
    check("model.w2.err",   int'(err_b),    int'(m_err));
    check("model.w2.pulse", int'(pulse_b),  int'(m_pulse));
    check("model.w2.lock",  int'(locked_b), int'(m_mode == 2));
    check("model.wrap2",    int'(wrap_b),   w2);
  endtask

  // One clock: drive, clock, sample 1 time unit after the edge, check model
  task automatic cycle(input bit r, input bit e, input bit cl, input int c);
    reset = r; en = e; clr = cl; c_in = 2'(c);
    @(posedge clk);
    #1;
    model_step(r, e, cl, c);
    check_model();
  endtask

  typedef struct {
    bit r, e, cl;
    int c;
    int st, lk, er, pu, wr;
  } vec_t;

  vec_t vt[$];

  task automatic add(input bit r, input bit e, input bit cl, input int c,
                     input int st, input int lk, input int er, input int pu, input int wr);
    vec_t v;
    v.r = r; v.e = e; v.cl = cl; v.c = c;
    v.st = st; v.lk = lk; v.er = er; v.pu = pu; v.wr = wr;
    vt.push_back(v);
  endtask

  initial begin
    int last_c;
    reset = 1'b0; en = 1'b0; clr = 1'b0; c_in = 2'd0;
    m_mode = 0; m_prev = 0; m_run = 0; m_wraps = 0; m_err = 1'b0; m_pulse = 1'b0;

    // Basic lock and wrap
    add(0,0,0,0, 0,0,0,0,0);
    add(1,1,0,0, 1,0,0,0,0);
    add(1,1,0,1, 1,0,0,0,0);
    add(1,1,0,2, 2,1,0,0,0);
    add(1,1,0,3, 2,1,0,0,0);
    add(1,1,0,0, 2,1,0,0,1);
    // Jump 1->3 while locked, error is sticky and ignores en, clr recovers
    add(1,1,0,1, 2,1,0,0,1);
    add(1,1,0,3, 3,0,1,1,1);
    add(1,1,0,0, 3,0,1,0,1);
    add(1,0,0,1, 3,0,1,0,1);
    add(1,1,1,2, 0,0,0,0,0);
    add(1,0,0,3, 0,0,0,0,0);
    // Glitch during acquisition; 3->0 in ACQ does not count as a wrap
    add(1,1,0,0, 1,0,0,0,0);
    add(1,1,0,1, 1,0,0,0,0);
    add(1,1,0,3, 1,0,0,0,0);
    add(1,1,0,0, 1,0,0,0,0);
    add(1,1,0,1, 2,1,0,0,0);
    // Hold while locked
    add(1,1,0,2, 2,1,0,0,0);
    if (C_STALL_OK) begin
      add(1,1,0,2, 2,1,0,0,0);
      add(1,1,0,2, 2,1,0,0,0);
    end else begin
      add(1,1,0,2, 3,0,1,1,0);
      add(1,1,0,2, 3,0,1,0,0);
    end
    // Reset overrides clr and en
    add(0,1,1,3, 0,0,0,0,0);

    for (int i = 0; i < vt.size(); i++) begin
      cycle(vt[i].r, vt[i].e, vt[i].cl, vt[i].c);
      check("tbl.state",  int'(state_a),  vt[i].st);
      check("tbl.locked", int'(locked_a), vt[i].lk);
      check("tbl.err",    int'(err_a),    vt[i].er);
      check("tbl.pulse",  int'(pulse_a),  vt[i].pu);
      check("tbl.wrap",   int'(wrap_a),   vt[i].wr);
    end

    // Five full wraps: narrow counter saturates at 3, wide one reaches 5
    cycle(1,1,0,0); cycle(1,1,0,1); cycle(1,1,0,2);
    for (int w = 0; w < 5; w++) begin
      cycle(1,1,0,3); cycle(1,1,0,0); cycle(1,1,0,1); cycle(1,1,0,2);
    end
    check("sat.wrap2",  int'(wrap_b),   3);
    check("sat.wrap8",  int'(wrap_a),   5);
    check("sat.locked", int'(locked_b), 1);
    // Single reset edge from LOCKED with saturated counter
    cycle(0,1,0,3);
    check("rst.state",  int'(state_b),  0);
    check("rst.locked", int'(locked_b), 0);
    check("rst.err",    int'(err_b),    0);
    check("rst.pulse",  int'(pulse_b),  0);
    check("rst.wrap2",  int'(wrap_b),   0);
    check("rst.wrap8",  int'(wrap_a),   0);

    // Randomized run, mostly well-behaved counting with occasional faults
    last_c = 0;
    for (int k = 0; k < 3000; k++) begin
      bit r, e, cl;
      int c;
      r  = ($urandom_range(0, 127) != 0);
      cl = ($urandom_range(0, 63) == 0);
      e  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 8) c = (last_c + 1) % 4;
      else c = $urandom_range(0, 3);
      if (e) last_c = c;
      cycle(r, e, cl, c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
